// File: rtl/ps2_keycode.sv
// PS/2 keyboard receiver with a small game-key decoder: frames raw PS/2 bytes,
// then tracks held keys A/D/space/enter and reports the most recent one as a HID code.
module ps2_keycode #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic [7:0] scancode,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_meta, clk_sync, clk_prev;
    logic          data_meta, data_sync;
    logic          fall;
    state_t        state, state_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shift_reg, shift_nxt;
    logic          parity_ok, parity_nxt;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          load, err;

    // Synchronizers idle high, matching an idle PS/2 bus, so no edge appears at reset release.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    assign fall    = clk_prev & ~clk_sync;
    assign timeout = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_reg;
        parity_nxt  = parity_ok;
        load        = 1'b0;
        err         = 1'b0;
        if (timeout) begin
            state_nxt = IDLE;
            err       = 1'b1;
        end else if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!data_sync) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = 3'd0;
                    end else begin
                        err = 1'b1;
                    end
                end
                DATA: begin
                    shift_nxt   = {data_sync, shift_reg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: begin
                    parity_nxt = ^{shift_reg, data_sync};
                    state_nxt  = STOP;
                end
                STOP: begin
                    if (data_sync && parity_ok) load = 1'b1;
                    else                        err  = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            parity_ok  <= 1'b0;
            to_cnt     <= '0;
            scancode   <= 8'h00;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift_reg  <= shift_nxt;
            parity_ok  <= parity_nxt;
            to_cnt     <= (fall || state == IDLE) ? '0 : to_cnt + TW'(1);
            scan_valid <= load;
            frame_err  <= err;
            if (load) scancode <= shift_reg;
        end
    end

    // Key decoder: index order doubles as fallback priority (A > D > space > enter).
    logic       brk_pending, ext_pending;
    logic [3:0] held, held_after_break;
    logic       key_hit;
    logic [1:0] key_idx;
    logic [7:0] key_hid, fallback;

    always_comb begin
        key_hit = 1'b1;
        key_idx = 2'd0;
        key_hid = 8'h04;
        unique case (scancode)
            8'h1C: begin key_idx = 2'd0; key_hid = 8'h04; end
            8'h23: begin key_idx = 2'd1; key_hid = 8'h07; end
            8'h29: begin key_idx = 2'd2; key_hid = 8'h2C; end
            8'h5A: begin key_idx = 2'd3; key_hid = 8'h28; end
            default: key_hit = 1'b0;
        endcase
        held_after_break = held & ~(4'b0001 << key_idx);
        if      (held_after_break[0]) fallback = 8'h04;
        else if (held_after_break[1]) fallback = 8'h07;
        else if (held_after_break[2]) fallback = 8'h2C;
        else if (held_after_break[3]) fallback = 8'h28;
        else                          fallback = 8'h00;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            brk_pending <= 1'b0;
            ext_pending <= 1'b0;
            held        <= 4'b0000;
            keycode     <= 8'h00;
        end else if (scan_valid) begin
            if (scancode == 8'hF0) begin
                brk_pending <= 1'b1;
            end else if (scancode == 8'hE0) begin
                ext_pending <= 1'b1;
            end else begin
                brk_pending <= 1'b0;
                ext_pending <= 1'b0;
                if (key_hit && !ext_pending) begin
                    if (brk_pending) begin
                        if (held[key_idx]) begin
                            held <= held_after_break;
                            if (keycode == key_hid) keycode <= fallback;
                        end
                    end else if (!held[key_idx]) begin
                        held[key_idx] <= 1'b1;
                        keycode       <= key_hid;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode.sv
// Self-checking bench for ps2_keycode: directed scenarios with literal expectations,
// then random frames checked every cycle against a frame-level behavioural model.
module tb_ps2_keycode;

    localparam int TO   = 300;
    localparam int HALF = 6;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode, scancode;
    logic       scan_valid, frame_err;

    always #5 Clk = ~Clk;

    ps2_keycode #(.TIMEOUT_CYCLES(TO)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .keycode    (keycode),
        .scancode   (scancode),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Expected pulse events, pushed by stimulus, consumed by the monitor.
    typedef struct {
        bit         is_err;
        logic [7:0] b;
    } ev_t;
    ev_t exp_q[$];

    // Behavioural model of the key decoder.
    logic [7:0] sc_tab [4] = '{8'h1C, 8'h23, 8'h29, 8'h5A};
    logic [7:0] hid_tab[4] = '{8'h04, 8'h07, 8'h2C, 8'h28};
    bit         m_held[4];
    logic [7:0] m_key;
    bit         m_brk, m_ext;
    bit         mon_en = 1'b0;
    int         n_sv = 0, n_fe = 0;

    function automatic void model_reset();
        foreach (m_held[i]) m_held[i] = 1'b0;
        m_key = 8'h00;
        m_brk = 1'b0;
        m_ext = 1'b0;
    endfunction

    function automatic void model_apply(input logic [7:0] b);
        int idx = -1;
        if (b == 8'hF0) begin
            m_brk = 1'b1;
            return;
        end
        if (b == 8'hE0) begin
            m_ext = 1'b1;
            return;
        end
        for (int i = 0; i < 4; i++) if (sc_tab[i] == b) idx = i;
        if (idx >= 0 && !m_ext) begin
            if (m_brk) begin
                if (m_held[idx]) begin
                    m_held[idx] = 1'b0;
                    if (m_key == hid_tab[idx]) begin
                        m_key = 8'h00;
                        for (int i = 3; i >= 0; i--) if (m_held[i]) m_key = hid_tab[i];
                    end
                end
            end else if (!m_held[idx]) begin
                m_held[idx] = 1'b1;
                m_key = hid_tab[idx];
            end
        end
        m_brk = 1'b0;
        m_ext = 1'b0;
    endfunction

    // Compare process: keycode every cycle, pulses against the expected-event queue.
    always @(negedge Clk) begin
        if (mon_en) begin
            ev_t ev;
            check("keycode", keycode, m_key);
            check("pulse_exclusive", {7'd0, scan_valid & frame_err}, 8'h00);
            if (scan_valid) n_sv++;
            if (frame_err)  n_fe++;
            if (scan_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_pulse: scan_valid=%0b frame_err=%0b expected none",
                             scan_valid, frame_err);
                end else begin
                    ev = exp_q.pop_front();
                    check("pulse_is_err", {7'd0, frame_err}, {7'd0, ev.is_err});
                    if (scan_valid && !ev.is_err) begin
                        check("scancode", scancode, ev.b);
                        model_apply(ev.b);
                    end
                end
            end
        end
    end

    task automatic ps2_bit(input bit d);
        ps2_data = d;
        repeat (HALF) @(posedge Clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge Clk);
        ps2_clk = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge Clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d events outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        ev_t ev;
        ev.is_err = bad_par | bad_stop;
        ev.b      = b;
        exp_q.push_back(ev);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        wait_drain(60);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_keycode"},    keycode,             8'h00);
        check({tag, "_scancode"},   scancode,            8'h00);
        check({tag, "_scan_valid"}, {7'd0, scan_valid},  8'h00);
        check({tag, "_frame_err"},  {7'd0, frame_err},   8'h00);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sv0, fe0;
        ev_t ev;
        model_reset();
        repeat (5) @(negedge Clk);
        check_reset_outputs("por");
        Reset = 1'b1;
        @(negedge Clk);
        mon_en = 1'b1;

        // Single make, then the make/break sequence with literal expectations.
        sv0 = n_sv;
        send_frame(8'h1C, 0, 0);
        check("lit_1C_keycode", keycode, 8'h04);
        check("lit_1C_scancode", scancode, 8'h1C);
        check("lit_1C_one_pulse", 8'(n_sv - sv0), 8'd1);
        check("model_1C", m_key, 8'h04);
        send_frame(8'h23, 0, 0);
        check("lit_D_keycode", keycode, 8'h07);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h23, 0, 0);
        check("lit_Dbrk_keycode", keycode, 8'h04);
        check("model_Dbrk", m_key, 8'h04);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        check("lit_Abrk_keycode", keycode, 8'h00);

        // Bad parity, bad stop and a lone start-bit error.
        sv0 = n_sv; fe0 = n_fe;
        send_frame(8'h1C, 1, 0);
        check("lit_badpar_fe", 8'(n_fe - fe0), 8'd1);
        check("lit_badpar_sv", 8'(n_sv - sv0), 8'd0);
        check("lit_badpar_keycode", keycode, 8'h00);
        send_frame(8'h29, 0, 1);
        check("lit_badstop_keycode", keycode, 8'h00);
        fe0 = n_fe;
        ev.is_err = 1'b1; ev.b = 8'h00;
        exp_q.push_back(ev);
        ps2_bit(1'b1);
        wait_drain(40);
        check("lit_startbit_fe", 8'(n_fe - fe0), 8'd1);

        // Partial frame abandoned by the timeout, then normal reception.
        fe0 = n_fe;
        exp_q.push_back(ev);
        ps2_bit(1'b0);
        for (int i = 0; i < 7; i++) ps2_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
        wait_drain(TO + 60);
        check("lit_timeout_fe", 8'(n_fe - fe0), 8'd1);
        send_frame(8'h23, 0, 0);
        check("lit_after_to_keycode", keycode, 8'h07);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h23, 0, 0);
        check("lit_after_to_release", keycode, 8'h00);

        // Extended code ignored; typematic repeats keep the key.
        send_frame(8'hE0, 0, 0);
        send_frame(8'h1C, 0, 0);
        check("lit_ext_keycode", keycode, 8'h00);
        sv0 = n_sv;
        for (int i = 0; i < 3; i++) send_frame(8'h1C, 0, 0);
        check("lit_repeat_keycode", keycode, 8'h04);
        check("lit_repeat_pulses", 8'(n_sv - sv0), 8'd3);

        // Reset mid-frame after five data bits, with A still held.
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        mon_en = 1'b0;
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        check_reset_outputs("midrst");
        exp_q.delete();
        model_reset();
        Reset = 1'b1;
        @(negedge Clk);
        mon_en = 1'b1;
        send_frame(8'h5A, 0, 0);
        check("lit_after_rst_keycode", keycode, 8'h28);
        check("lit_after_rst_scancode", scancode, 8'h5A);

        // Random traffic against the model.
        for (int f = 0; f < 160; f++) begin
            logic [7:0] b;
            int r = $urandom_range(0, 9);
            if (r < 4)       b = sc_tab[r];
            else if (r < 6)  b = 8'hF0;
            else if (r == 6) b = 8'hE0;
            else             b = 8'($urandom_range(0, 255));
            send_frame(b, $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0);
        end

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
